// File: rtl/demux_1_a_4_if.sv
// demux_1_a_4_if -- bundles the input handshake (word, channel select, valid/ready)
// and the four-channel output handshake (held words, valid flags, consumer readies)
// plus the delivered-word counter of demux_1_a_4.
//   slave  : the demux side (consumes i_*, drives o_*)
//   master : the environment side (drives i_*, observes o_*)
interface demux_1_a_4_if #(
  parameter int n = 4
);
  logic [n-1:0] i_Datos;
  logic [1:0]   i_sel;
  logic         i_valid;
  logic         o_ready;
  logic [n-1:0] o_Datos_0;
  logic [n-1:0] o_Datos_1;
  logic [n-1:0] o_Datos_2;
  logic [n-1:0] o_Datos_3;
  logic [3:0]   o_valid;
  logic [3:0]   i_ready;
  logic [7:0]   o_total;

  modport slave (
    input  i_Datos, i_sel, i_valid, i_ready,
    output o_ready, o_Datos_0, o_Datos_1, o_Datos_2, o_Datos_3, o_valid, o_total
  );

  modport master (
    output i_Datos, i_sel, i_valid, i_ready,
    input  o_ready, o_Datos_0, o_Datos_1, o_Datos_2, o_Datos_3, o_valid, o_total
  );
endinterface

// File: rtl/demux_1_a_4.sv
// demux_1_a_4 -- 1-to-4 demultiplexer with a one-word holding register per channel.
// An incoming word is steered to channel i_sel and held there until that channel's
// consumer takes it; o_total counts delivered words modulo 256.
// Ports:
//   i_clk   : clock, all state on rising edge
//   i_rst_n : asynchronous active-low reset, clears all holding registers and o_total
//   bus     : demux_1_a_4_if.slave (i_Datos/i_sel/i_valid/o_ready on the input side,
//             o_Datos_0..3/o_valid/i_ready per channel, o_total counter)
module demux_1_a_4 #(
  parameter int n = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  demux_1_a_4_if.slave   bus
);

  logic [n-1:0] data_q [4];
  logic [3:0]   valid_q;
  logic [7:0]   total_q;

  logic [3:0]   deliver;
  logic [3:0]   load;
  logic         ready;
  logic [2:0]   n_deliv;

  always_comb begin
    deliver = valid_q & bus.i_ready;
    // A channel can take a word if it is empty or is being drained at this same edge.
    ready   = !valid_q[bus.i_sel] | bus.i_ready[bus.i_sel];
    load    = 4'b0000;
    if (bus.i_valid && ready) begin
      load[bus.i_sel] = 1'b1;
    end
    n_deliv = 3'(deliver[0]) + 3'(deliver[1]) + 3'(deliver[2]) + 3'(deliver[3]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 4'b0000;
      total_q <= 8'h00;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      // Load wins over delivery so a simultaneous drain/refill keeps the flag set.
      valid_q <= (valid_q & ~deliver) | load;
      total_q <= total_q + 8'(n_deliv);
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          data_q[k] <= bus.i_Datos;
        end
      end
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_valid   = valid_q;
  assign bus.o_total   = total_q;
  assign bus.o_Datos_0 = data_q[0];
  assign bus.o_Datos_1 = data_q[1];
  assign bus.o_Datos_2 = data_q[2];
  assign bus.o_Datos_3 = data_q[3];

endmodule

// File: tb/tb_demux_1_a_4.sv
// tb_demux_1_a_4 -- directed scenarios with literal expectations followed by
// randomized traffic, all outputs compared every cycle against a behavioural model.
module tb_demux_1_a_4;
  logic i_clk;
  logic i_rst_n;
  int   checks;
  int   errors;

  demux_1_a_4_if #(.n(4)) bus ();

  demux_1_a_4 #(.n(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural model: each channel is a slot that is either full or empty.
  bit       m_full [4];
  int       m_word [4];
  int       m_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_full[k] = 1'b0;
        m_word[k] = 0;
      end
      m_total = 0;
    end else begin
      bit take;
      int s;
      s    = int'(bus.i_sel);
      take = bus.i_valid && (!m_full[s] || bus.i_ready[s]);
      for (int k = 0; k < 4; k++) begin
        if (m_full[k] && bus.i_ready[k]) begin
          m_full[k] = 1'b0;
          m_total   = (m_total + 1) % 256;
        end
      end
      if (take) begin
        m_full[s] = 1'b1;
        m_word[s] = int'(bus.i_Datos);
      end
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      logic [3:0] mv;
      int         s;
      s  = int'(bus.i_sel);
      mv = {m_full[3], m_full[2], m_full[1], m_full[0]};
      check("cyc_o_valid", 32'(bus.o_valid), 32'(mv));
      check("cyc_o_total", 32'(bus.o_total), 32'(m_total));
      check("cyc_o_ready", 32'(bus.o_ready), 32'(!m_full[s] || bus.i_ready[s]));
      check("cyc_o_Datos_0", 32'(bus.o_Datos_0), 32'(m_word[0]));
      check("cyc_o_Datos_1", 32'(bus.o_Datos_1), 32'(m_word[1]));
      check("cyc_o_Datos_2", 32'(bus.o_Datos_2), 32'(m_word[2]));
      check("cyc_o_Datos_3", 32'(bus.o_Datos_3), 32'(m_word[3]));
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input bit v, input int s, input int d, input logic [3:0] r);
    bus.i_valid = v;
    bus.i_sel   = 2'(s);
    bus.i_Datos = 4'(d);
    bus.i_ready = r;
  endtask

  // Leaves the bench 3 time units after a rising edge with reset released.
  task automatic apply_reset;
    drive(0, 0, 0, 4'h0);
    i_rst_n = 1'b0;
    tick;
    tick;
    #2;
    i_rst_n = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(bus.o_valid), 32'h0);
    check({tag, "_total"}, 32'(bus.o_total), 32'h0);
    check({tag, "_ready"}, 32'(bus.o_ready), 32'h1);
    check({tag, "_d0"}, 32'(bus.o_Datos_0), 32'h0);
    check({tag, "_d1"}, 32'(bus.o_Datos_1), 32'h0);
    check({tag, "_d2"}, 32'(bus.o_Datos_2), 32'h0);
    check({tag, "_d3"}, 32'(bus.o_Datos_3), 32'h0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    i_rst_n = 1'b0;
    drive(0, 0, 0, 4'h0);
    #3;
    check_cleared("rst");
    apply_reset;
    check_cleared("post_rst");

    // Single word into channel 2, consumer not ready.
    drive(1, 2, 4'hA, 4'h0);
    tick;
    bus.i_valid = 1'b0;
    #1;
    check("single_valid", 32'(bus.o_valid), 32'h4);
    check("single_d2", 32'(bus.o_Datos_2), 32'hA);
    check("single_total", 32'(bus.o_total), 32'h0);
    check("single_ready", 32'(bus.o_ready), 32'h0);

    // Backpressure on channel 1.
    apply_reset;
    drive(1, 1, 4'h3, 4'h0);
    tick;
    drive(1, 1, 4'h5, 4'h0);
    #1;
    check("bp_ready_low", 32'(bus.o_ready), 32'h0);
    tick;
    check("bp_hold_d1", 32'(bus.o_Datos_1), 32'h3);
    bus.i_ready = 4'b0010;
    #1;
    check("bp_ready_high", 32'(bus.o_ready), 32'h1);
    tick;
    drive(0, 1, 0, 4'h0);
    #1;
    check("bp_new_d1", 32'(bus.o_Datos_1), 32'h5);
    check("bp_valid", 32'(bus.o_valid), 32'h2);
    check("bp_total", 32'(bus.o_total), 32'h1);

    // Sweep with all consumers ready.
    apply_reset;
    for (int k = 0; k < 4; k++) begin
      drive(1, k, k + 1, 4'hF);
      tick;
      check("sweep_valid", 32'(bus.o_valid), 32'(1 << k));
      case (k)
        0: check("sweep_d0", 32'(bus.o_Datos_0), 32'h1);
        1: check("sweep_d1", 32'(bus.o_Datos_1), 32'h2);
        2: check("sweep_d2", 32'(bus.o_Datos_2), 32'h3);
        default: check("sweep_d3", 32'(bus.o_Datos_3), 32'h4);
      endcase
    end
    drive(0, 0, 0, 4'hF);
    tick;
    check("sweep_drained", 32'(bus.o_valid), 32'h0);
    check("sweep_total", 32'(bus.o_total), 32'h4);

    // Parallel drain of all four channels at one edge.
    for (int k = 0; k < 4; k++) begin
      drive(1, k, $urandom_range(0, 15), 4'h0);
      tick;
    end
    drive(0, 0, 0, 4'h0);
    #1;
    check("par_full", 32'(bus.o_valid), 32'hF);
    bus.i_ready = 4'hF;
    tick;
    bus.i_ready = 4'h0;
    #1;
    check("par_valid", 32'(bus.o_valid), 32'h0);
    check("par_total", 32'(bus.o_total), 32'h8);

    // Counter wrap after 256 deliveries.
    apply_reset;
    for (int i = 0; i < 256; i++) begin
      drive(1, $urandom_range(0, 3), $urandom_range(0, 15), 4'hF);
      tick;
    end
    drive(0, 0, 0, 4'hF);
    tick;
    check("wrap_zero", 32'(bus.o_total), 32'h0);
    drive(1, 3, 4'h9, 4'hF);
    tick;
    drive(0, 0, 0, 4'hF);
    tick;
    check("wrap_one", 32'(bus.o_total), 32'h1);

    // Asynchronous reset between edges with traffic buffered.
    apply_reset;
    for (int i = 0; i < 7; i++) begin
      drive(1, i % 4, i + 1, 4'hF);
      tick;
    end
    drive(0, 0, 0, 4'hF);
    tick;
    drive(1, 0, 4'h1, 4'h0);
    tick;
    drive(1, 1, 4'h2, 4'h0);
    tick;
    drive(1, 3, 4'h4, 4'h0);
    tick;
    drive(0, 0, 0, 4'h0);
    #1;
    check("ar_pre_valid", 32'(bus.o_valid), 32'hB);
    check("ar_pre_total", 32'(bus.o_total), 32'h7);
    #1;
    i_rst_n = 1'b0;
    #1;
    check_cleared("ar");
    tick;
    #2;
    i_rst_n = 1'b1;

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 15),
            4'($urandom_range(0, 15)));
      tick;
      if (i == 700) begin
        #1;
        i_rst_n = 1'b0;
        #1;
        check("rand_rst_valid", 32'(bus.o_valid), 32'h0);
        check("rand_rst_total", 32'(bus.o_total), 32'h0);
        #1;
        i_rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_1_a_4.md
DEMUX_1_A_4 -- requirements
Module: demux_1_a_4

Interface
REQ-001 SHALL have parameter n, default 4, giving the data width in bits.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_Datos  input  n  incoming data word.
REQ-005 SHALL have port i_sel  input  2  destination channel of the incoming word (0..3).
REQ-006 SHALL have port i_valid  input  1  incoming word present.
REQ-007 SHALL have port o_ready  output  1  block can take the incoming word this cycle.
REQ-008 SHALL have ports o_Datos_0, o_Datos_1, o_Datos_2, o_Datos_3  output  n each  per-channel held word.
REQ-009 SHALL have port o_valid  output  4  bit k means channel k holds a word.
REQ-010 SHALL have port i_ready  input  4  bit k means the channel k consumer takes the word this cycle.
REQ-011 SHALL have port o_total  output  8  count of words delivered on all channels.

Function
REQ-012 SHALL contain, for each channel k, a one-word holding register driving o_Datos_k and a valid flag driving o_valid[k].
REQ-013 SHALL drive o_ready = !o_valid[i_sel] | i_ready[i_sel]: combinational, independent of i_valid.
REQ-014 SHALL define input acceptance as i_valid & o_ready sampled at a rising edge; on acceptance, the register for channel i_sel loads i_Datos and its valid flag is set.
REQ-015 SHALL present an accepted word on the outputs starting in the cycle after the accepting edge (latency 1), never in the same cycle.
REQ-016 SHALL define output delivery on channel k as o_valid[k] & i_ready[k] at a rising edge; the flag clears at that edge unless the rule in REQ-017 applies.
REQ-017 SHALL, when delivery on channel k and acceptance into channel k occur at the same edge, keep o_valid[k] at 1 and load the new word, with no bubble.
REQ-018 SHALL drain all four channels independently; any subset, including all four, may deliver at the same edge.
REQ-019 SHALL hold o_Datos_k stable while o_valid[k]=1 and the word has not been delivered.
REQ-020 SHALL NOT let o_valid depend combinationally on i_ready or i_valid; o_valid is driven only from registers.
REQ-021 SHALL ignore i_sel and i_Datos while i_valid=0; i_sel may change in any cycle.
REQ-022 SHALL never drop or overwrite an undelivered word; when o_ready=0, the input word stays pending at the source.
REQ-023 SHALL increment o_total at each edge by the number of deliveries at that edge (0..4), modulo 256 with wrap-around.
REQ-024 SHALL leave o_Datos_k at its last value after its word is delivered; the value is don't-care while o_valid[k]=0, but the register is not cleared.

Reset
REQ-025 SHALL, while i_rst_n=0 and without waiting for a clock edge, force o_valid=4'b0000, every o_Datos_k to 0, and o_total to 0.
REQ-026 SHALL give o_ready=1 during and immediately after reset, since all channels are empty.
REQ-027 SHALL discard buffered words when reset is asserted mid-operation; discarded words are not counted in o_total.
REQ-028 SHALL allow the first acceptance at the first rising edge with i_rst_n=1.

Verification
REQ-029 Single word: after reset, apply i_sel=2, i_Datos=4'hA, i_valid=1 for one cycle, i_ready=0 -> next cycle o_valid=4'b0100, o_Datos_2=4'hA, o_total=0, and o_ready=0 while i_sel=2.
REQ-030 Backpressure: channel 1 holds 4'h3, i_ready[1]=0, then apply i_sel=1, i_Datos=4'h5, i_valid=1 -> o_ready=0 and o_Datos_1 stays 4'h3; raise i_ready[1] -> o_ready=1, next cycle o_Datos_1=4'h5, o_valid[1]=1, o_total=1.
REQ-031 Sweep: i_ready=4'hF, send data 1,2,3,4 to i_sel 0,1,2,3 on consecutive cycles -> each o_valid bit high for exactly one cycle with the matching data; o_total=4 after the drain.
REQ-032 Parallel drain: fill all four channels with i_ready=0, then set i_ready=4'hF for one cycle -> o_valid=4'b0000 and o_total increases by 4 at that single edge.
REQ-033 Wrap: make 256 deliveries from reset -> o_total returns to 8'h00; one more delivery -> 8'h01.
REQ-034 Async reset: with o_valid=4'b1011 and o_total=8'h07, drive i_rst_n low between clock edges -> o_valid=0, o_total=0, and all o_Datos_k=0 immediately; o_ready=1.
